// File: rtl/transmission_scan_ctrl.sv
// Sequencer for the 8-bit select/transmission stage: steps select 0..7, rebuilds the byte.
// Optional compare logic is built when TRANSMISSION_CHECK_EN is defined.
module transmission_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iValid,
    output logic       oReady,
    input  logic [7:0] iByte,
    output logic [7:0] oTxData,
    output logic       oA,
    output logic       oB,
    output logic       oC,
    input  logic [7:0] iRxData,
    output logic       oValid,
    input  logic       iReady,
    output logic [7:0] oByte,
    output logic       oBusy,
    output logic       oErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx;
    logic [7:0]       r_byte;
    logic             r_valid;
    logic             w_idle;
    logic             w_accept;
    logic             w_sample;

    // Any encoding other than SCAN/DONE behaves as IDLE.
    assign w_idle   = (r_state != ST_SCAN) && (r_state != ST_DONE);
    assign w_accept = w_idle && iValid;
    assign w_sample = (r_state == ST_SCAN) && (r_cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = iValid ? ST_SCAN : ST_IDLE;
            ST_SCAN: if (w_sample && (r_sel == 3'd7)) w_next = ST_DONE;
            ST_DONE: if (r_valid && iReady) w_next = ST_IDLE;
            default: w_next = iValid ? ST_SCAN : ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sel   <= 3'd0;
            r_cnt   <= '0;
            r_tx    <= 8'h00;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_tx   <= iByte;
            r_byte <= 8'h00;
            r_sel  <= 3'd0;
            r_cnt  <= '0;
        end else if (r_state == ST_SCAN) begin
            if (w_sample) begin
                r_byte[r_sel] <= iRxData[r_sel];
                r_cnt         <= '0;
                if (r_sel != 3'd7) r_sel <= r_sel + 3'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (r_state == ST_DONE) begin
            // oValid rises one edge after entering DONE, giving 8*DWELL+1 edges of latency.
            if (!r_valid) begin
                r_valid <= 1'b1;
            end else if (iReady) begin
                r_valid <= 1'b0;
                r_sel   <= 3'd0;
            end
        end
    end

`ifdef TRANSMISSION_CHECK_EN
    logic r_err;
    logic w_mismatch;

    // The stage must pass only the selected bit and zero all others.
    assign w_mismatch = (iRxData[r_sel] != r_tx[r_sel]) ||
                        ((iRxData & ~(8'h01 << r_sel)) != 8'h00);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                    r_err <= 1'b0;
        else if (w_accept)              r_err <= 1'b0;
        else if (w_sample && w_mismatch) r_err <= 1'b1;
    end

    assign oErr = r_err;
`else
    assign oErr = 1'b0;
`endif

    assign {oA, oB, oC} = r_sel;
    assign oReady       = w_idle;
    assign oBusy        = !w_idle;
    assign oTxData      = r_tx;
    assign oByte        = r_byte;
    assign oValid       = r_valid;

endmodule

// File: tb/tb_transmission_scan_ctrl.sv
// Directed self-checking bench for transmission_scan_ctrl with a behavioural stage model.
// Compile with TRANSMISSION_CHECK_EN to exercise the error-flag path.
module tb_transmission_scan_ctrl;

`ifdef TRANSMISSION_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iValid;
    logic       oReady;
    logic [7:0] iByte;
    logic [7:0] oTxData;
    logic       oA, oB, oC;
    logic [7:0] iRxData;
    logic       oValid;
    logic       iReady;
    logic [7:0] oByte;
    logic       oBusy;
    logic       oErr;

    logic       rx_ovr_en;
    logic [7:0] rx_ovr;
    logic       fault_en;
    int         n_checks;
    int         n_pass;

    always #5 iClk = ~iClk;

    // Correct stage: passes only the selected data bit, all others 0.
    function automatic logic [7:0] stage_model(input logic [7:0] d, input logic [2:0] s);
        logic [7:0] o;
        o    = 8'h00;
        o[s] = d[s];
        return o;
    endfunction

    assign iRxData = rx_ovr_en ? rx_ovr :
                     (stage_model(oTxData, {oA, oB, oC}) |
                      ((fault_en && ({oA, oB, oC} == 3'd2)) ? 8'h40 : 8'h00));

    transmission_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iValid  (iValid),
        .oReady  (oReady),
        .iByte   (iByte),
        .oTxData (oTxData),
        .oA      (oA),
        .oB      (oB),
        .oC      (oC),
        .iRxData (iRxData),
        .oValid  (oValid),
        .iReady  (iReady),
        .oByte   (oByte),
        .oBusy   (oBusy),
        .oErr    (oErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic start(input logic [7:0] b);
        iValid = 1'b1;
        iByte  = b;
        check("ready_before_accept", {31'd0, oReady}, 32'd1);
        step();
        iValid = 1'b0;
        check("busy_after_accept", {31'd0, oBusy}, 32'd1);
    endtask

    // Waits for oValid from the negedge after accept; optionally checks latency and select stepping.
    task automatic wait_done(input logic [7:0] exp, input bit chk_lat, input bit chk_sel);
        int k;
        k = 0;
        while (!oValid && k < 60) begin
            if (chk_sel && k < 16) check($sformatf("sel_step_%0d", k), {29'd0, oA, oB, oC}, k / 2);
            step();
            k++;
        end
        check("valid_seen", {31'd0, oValid}, 32'd1);
        if (chk_lat) check("latency_edges", k, 32'd17);
        check("rebuilt_byte", {24'd0, oByte}, {24'd0, exp});
    endtask

    task automatic handshake();
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        check("valid_dropped", {31'd0, oValid}, 32'd0);
        check("ready_back", {31'd0, oReady}, 32'd1);
        check("idle_not_busy", {31'd0, oBusy}, 32'd0);
    endtask

    task automatic wait_sel(input logic [2:0] s);
        int k;
        k = 0;
        while ({oA, oB, oC} != s && k < 40) begin
            step();
            k++;
        end
        check("sel_reached", {29'd0, oA, oB, oC}, {29'd0, s});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, oValid}, 32'd0);
        check({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
        check({tag, "_sel"}, {29'd0, oA, oB, oC}, 32'd0);
        check({tag, "_txdata"}, {24'd0, oTxData}, 32'd0);
        check({tag, "_byte"}, {24'd0, oByte}, 32'd0);
        check({tag, "_err"}, {31'd0, oErr}, 32'd0);
        check({tag, "_ready"}, {31'd0, oReady}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        iRst_n    = 1'b0;
        iValid    = 1'b0;
        iByte     = 8'h00;
        iReady    = 1'b0;
        rx_ovr_en = 1'b1;
        rx_ovr    = 8'h00;
        fault_en  = 1'b0;

        // Reset held for 3 cycles while inputs toggle randomly.
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            iValid = 1'($urandom);
            iReady = 1'($urandom);
            iByte  = 8'($urandom);
            rx_ovr = 8'($urandom);
            check_reset_outputs("reset");
        end
        @(negedge iClk);
        iValid    = 1'b0;
        iReady    = 1'b0;
        rx_ovr_en = 1'b0;
        iRst_n    = 1'b1;
        @(negedge iClk);
        check_reset_outputs("post_reset");

        // Basic A5 scan with select stepping and latency.
        start(8'hA5);
        wait_done(8'hA5, 1'b1, 1'b1);
        handshake();

        // Back-pressure in DONE.
        start(8'h3C);
        wait_done(8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid_held", {31'd0, oValid}, 32'd1);
            check("bp_byte_held", {24'd0, oByte}, 32'h3C);
        end
        handshake();

        // iValid asserted during SCAN is ignored until the return to IDLE.
        start(8'h12);
        step();
        step();
        iValid = 1'b1;
        iByte  = 8'hFF;
        check("busy_not_ready", {31'd0, oReady}, 32'd0);
        wait_done(8'h12, 1'b0, 1'b0);
        check("tx_kept_12", {24'd0, oTxData}, 32'h12);
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        check("idle_after_release", {31'd0, oReady}, 32'd1);
        check("ff_not_yet_taken", {24'd0, oTxData}, 32'h12);
        step();
        iValid = 1'b0;
        check("ff_accepted", {24'd0, oTxData}, 32'hFF);
        check("ff_busy", {31'd0, oBusy}, 32'd1);
        wait_done(8'hFF, 1'b1, 1'b0);
        handshake();

        // Reset pulse mid-scan.
        start(8'hF0);
        wait_sel(3'd3);
        iRst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        start(8'h0F);
        wait_done(8'h0F, 1'b1, 1'b0);
        handshake();

        // Faulty stage drives bit 6 while sel=2.
        fault_en = 1'b1;
        start(8'h00);
        wait_sel(3'd2);
        check("err_before_fault_sample", {31'd0, oErr}, 32'd0);
        wait_sel(3'd3);
        check("err_after_fault_sample", {31'd0, oErr}, {31'd0, CHK_EN});
        wait_done(8'h00, 1'b0, 1'b0);
        check("err_sticky_done", {31'd0, oErr}, {31'd0, CHK_EN});
        handshake();
        check("err_sticky_idle", {31'd0, oErr}, {31'd0, CHK_EN});
        fault_en = 1'b0;
        start(8'h5A);
        check("err_cleared_on_accept", {31'd0, oErr}, 32'd0);
        wait_done(8'h5A, 1'b1, 1'b0);
        check("err_clean_run", {31'd0, oErr}, 32'd0);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
